// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with branch/jump/return and a hardware return-address stack
module pc_unit #(
  parameter int              WIDTH        = 16,
  parameter int              DISP_WIDTH   = 8,
  parameter int              STACK_DEPTH  = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [1:0]                   pc_sel,
  input  logic                         call,
  input  logic [WIDTH-1:0]             target,
  input  logic [DISP_WIDTH-1:0]        disp,
  input  logic                         clr_err,
  output logic [WIDTH-1:0]             pc,
  output logic [$clog2(STACK_DEPTH):0] depth,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] FULL_DEPTH = DW'(STACK_DEPTH);

  localparam logic [1:0] SEL_INC  = 2'b00;
  localparam logic [1:0] SEL_JUMP = 2'b01;
  localparam logic [1:0] SEL_REL  = 2'b10;
  localparam logic [1:0] SEL_RET  = 2'b11;

  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] disp_ext;
  logic [WIDTH-1:0] top_value;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic             full;
  logic             empty;
  logic             push_req;
  logic             pop_req;
  logic             do_push;
  logic             do_pop;
  logic [WIDTH-1:0] pc_next;
  logic [DW-1:0]    depth_next;

  assign pc_inc    = pc + WIDTH'(1);
  assign disp_ext  = WIDTH'($signed(disp));
  // When full, depth's low bits wrap to 0, so rd_idx still lands on the top entry.
  assign wr_idx    = depth[AW-1:0];
  assign rd_idx    = depth[AW-1:0] - AW'(1);
  assign top_value = stack_mem[rd_idx];
  assign full      = (depth == FULL_DEPTH);
  assign empty     = (depth == '0);

  // Only calls paired with a redirect push; returns pop. Stall suppresses both.
  assign push_req  = !stall && call && (pc_sel == SEL_JUMP || pc_sel == SEL_REL);
  assign pop_req   = !stall && (pc_sel == SEL_RET);
  assign do_push   = push_req && !full;
  assign do_pop    = pop_req && !empty;

  // Next-PC and next-depth selection
  always_comb begin
    pc_next    = pc;
    depth_next = depth;
    if (!stall) begin
      unique case (pc_sel)
        SEL_INC:  pc_next = pc_inc;
        SEL_JUMP: pc_next = target;
        SEL_REL:  pc_next = pc + disp_ext;
        SEL_RET:  pc_next = empty ? pc_inc : top_value;
        default:  pc_next = pc_inc;
      endcase
      if (do_push) depth_next = depth + DW'(1);
      if (do_pop)  depth_next = depth - DW'(1);
    end
  end

  // Stack storage needs no reset; depth alone defines which entries are valid
  always_ff @(posedge clk) begin
    if (do_push) stack_mem[wr_idx] <= pc_inc;
  end

  // Architectural state: PC, depth and sticky flags (new errors beat clr_err)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_VECTOR;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pc        <= pc_next;
      depth     <= depth_next;
      overflow  <= (overflow  && !clr_err) || (push_req && full);
      underflow <= (underflow && !clr_err) || (pop_req && empty);
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - randomized and directed self-checking bench for pc_unit
module tb_pc_unit;

  localparam logic [15:0] RV = 16'h0010;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  pc_sel;
  logic        call;
  logic [15:0] target;
  logic [7:0]  disp;
  logic        clr_err;
  logic [15:0] pc;
  logic [3:0]  depth;
  logic        overflow;
  logic        underflow;

  pc_unit #(
    .WIDTH(16), .DISP_WIDTH(8), .STACK_DEPTH(8), .RESET_VECTOR(RV)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel), .call(call),
    .target(target), .disp(disp), .clr_err(clr_err), .pc(pc), .depth(depth),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: PC value, return stack as a queue, sticky flags
  logic [15:0] m_pc;
  logic [15:0] m_stack[$];
  logic        m_of;
  logic        m_uf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RV;
    m_stack.delete();
    m_of = 1'b0;
    m_uf = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic [1:0] sel, input logic c,
                            input logic [15:0] t, input logic [7:0] d, input logic clr);
    logic [15:0] ret_addr;
    logic        e_of;
    logic        e_uf;
    e_of = 1'b0;
    e_uf = 1'b0;
    ret_addr = m_pc + 16'd1;
    if (!s) begin
      if (c && (sel == 2'd1 || sel == 2'd2)) begin
        if (m_stack.size() == 8) e_of = 1'b1;
        else m_stack.push_back(ret_addr);
      end
      case (sel)
        2'd0: m_pc = ret_addr;
        2'd1: m_pc = t;
        2'd2: m_pc = 16'(int'(m_pc) + int'($signed(d)));
        default: begin
          if (m_stack.size() > 0) m_pc = m_stack.pop_back();
          else begin
            m_pc = ret_addr;
            e_uf = 1'b1;
          end
        end
      endcase
    end
    m_of = (m_of && !clr) || e_of;
    m_uf = (m_uf && !clr) || e_uf;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, 32'(pc), 32'(m_pc));
    check({tag, ".depth"}, 32'(depth), 32'(m_stack.size()));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_of));
    check({tag, ".unf"}, 32'(underflow), 32'(m_uf));
  endtask

  task automatic step(input string tag, input logic s, input logic [1:0] sel, input logic c,
                      input logic [15:0] t, input logic [7:0] d, input logic clr);
    stall = s; pc_sel = sel; call = c; target = t; disp = d; clr_err = clr;
    @(posedge clk);
    #1;
    model_step(s, sel, c, t, d, clr);
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; pc_sel = 2'd0; call = 1'b0;
    target = '0; disp = '0; clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // Sequential increments from the reset vector
    for (int i = 0; i < 4; i++) step("inc", 1'b0, 2'd0, 1'b0, 16'h0, 8'h0, 1'b0);
    check("inc_end", 32'(pc), 32'h0014);

    // Wrap-around on increment and on negative branch
    step("jmp_ffff", 1'b0, 2'd1, 1'b0, 16'hFFFF, 8'h0, 1'b0);
    step("wrap_inc", 1'b0, 2'd0, 1'b0, 16'h0, 8'h0, 1'b0);
    check("wrap_zero", 32'(pc), 32'h0000);
    step("jmp_5", 1'b0, 2'd1, 1'b0, 16'h0005, 8'h0, 1'b0);
    step("br_neg5", 1'b0, 2'd2, 1'b0, 16'h0, 8'hFB, 1'b0);
    check("br_to_zero", 32'(pc), 32'h0000);
    step("br_m128", 1'b0, 2'd2, 1'b0, 16'h0, 8'h80, 1'b0);
    check("br_m128_pc", 32'(pc), 32'hFF80);

    // Single call/return pair
    step("jmp_20", 1'b0, 2'd1, 1'b0, 16'h0020, 8'h0, 1'b0);
    step("call_100", 1'b0, 2'd1, 1'b1, 16'h0100, 8'h0, 1'b0);
    check("call_depth", 32'(depth), 32'd1);
    step("ret_21", 1'b0, 2'd3, 1'b0, 16'h0, 8'h0, 1'b0);
    check("ret_pc", 32'(pc), 32'h0021);

    // Nine nested calls overflow a depth-8 stack, then unwind past empty
    for (int i = 0; i < 9; i++)
      step("nest_call", 1'b0, (i % 2 == 0) ? 2'd1 : 2'd2, 1'b1, 16'h1000 + 16'(i * 16), 8'h07, 1'b0);
    check("nest_depth", 32'(depth), 32'd8);
    check("nest_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) step("unwind", 1'b0, 2'd3, 1'b1, 16'h0, 8'h0, 1'b0);
    step("ret_empty", 1'b0, 2'd3, 1'b0, 16'h0, 8'h0, 1'b0);
    check("ret_empty_unf", 32'(underflow), 32'd1);
    step("clr_err", 1'b0, 2'd0, 1'b0, 16'h0, 8'h0, 1'b1);
    check("clr_flags", 32'({overflow, underflow}), 32'd0);

    // Stall holds everything even with a call+jump request
    step("pre_stall", 1'b0, 2'd1, 1'b1, 16'h0300, 8'h0, 1'b0);
    for (int i = 0; i < 3; i++) step("stall", 1'b1, 2'd1, 1'b1, 16'h0ABC, 8'h0, 1'b0);
    check("stall_pc", 32'(pc), 32'h0300);
    step("ret_stall", 1'b0, 2'd3, 1'b0, 16'h0, 8'h0, 1'b0);

    // Asynchronous reset with a populated stack
    for (int i = 0; i < 3; i++) step("fill3", 1'b0, 2'd1, 1'b1, 16'h0400, 8'h0, 1'b0);
    step("to_200", 1'b0, 2'd1, 1'b0, 16'h0200, 8'h0, 1'b0);
    check("pre_rst_depth", 32'(depth), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_rst_pc", 32'(pc), 32'(RV));
    check("async_rst_depth", 32'(depth), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("post_rst");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(7) == 0),
           2'($urandom_range(3)),
           1'($urandom_range(1)),
           16'($urandom),
           8'($urandom),
           ($urandom_range(11) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
